// File: rtl/counter_16bit.sv
// counter_16bit: photon-pulse counter.
// The asynchronous detector pulse `sig` is brought into the clk50Mhz domain
// through a SYNC_STAGES-deep flop chain. A history flop detects rising edges.
// Each detected edge advances a 16-bit count that either saturates at 0xFFFF
// or wraps to 0x0000, depending on SATURATE.
// `rst` clears every flop asynchronously. A `sig` level that is already high
// at release is therefore seen as one fresh rising edge.
module counter_16bit #(
  parameter int SYNC_STAGES = 2,   // must be >= 2
  parameter bit SATURATE    = 1'b1 // 1: hold at 0xFFFF, 0: wrap to 0x0000
) (
  input  logic        clk50Mhz,
  input  logic        rst,
  input  logic        sig,
  output logic [15:0] cnt
);

  // sync_q[0] is s1 (samples sig), sync_q[SYNC_STAGES-1] is sN
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sh;
  logic                   rise;
  logic [15:0]            cnt_next;

  // Synchronizer chain: shift the raw pulse toward sN
  always_ff @(posedge clk50Mhz or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig};
    end
  end

  // Edge history: remember last cycle's synchronized level
  always_ff @(posedge clk50Mhz or posedge rst) begin
    if (rst) begin
      sh <= 1'b0;
    end else begin
      sh <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~sh;

  // Next count: +1 on a rising edge, honouring the overflow policy
  always_comb begin
    cnt_next = cnt;
    if (rise) begin
      if (SATURATE && (cnt == 16'hFFFF)) begin
        cnt_next = cnt;
      end else begin
        cnt_next = cnt + 16'd1;
      end
    end
  end

  // Count register, driven straight to the output
  always_ff @(posedge clk50Mhz or posedge rst) begin
    if (rst) begin
      cnt <= 16'h0000;
    end else begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: tb/tb_counter_16bit.sv
// Testbench for counter_16bit: one saturating and one wrapping instance
// share clock, reset and sig. A bench-side count model pushes expected
// values into per-instance queues when a pulse is driven. Those values are
// popped and compared once the two-clock latency has elapsed.
`timescale 1ns/100ps
module tb_counter_16bit;

  logic        clk;
  logic        clk_en;
  logic        rst;
  logic        sig;
  logic [15:0] cnt_sat;
  logic [15:0] cnt_wrap;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_sat_q[$];
  logic [15:0] exp_wrap_q[$];
  logic [15:0] model_sat;
  logic [15:0] model_wrap;

  typedef struct {
    int          hi;
    int          lo;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[13];

  counter_16bit #(.SYNC_STAGES(2), .SATURATE(1'b1)) dut_sat (
    .clk50Mhz(clk),
    .rst     (rst),
    .sig     (sig),
    .cnt     (cnt_sat)
  );

  counter_16bit #(.SYNC_STAGES(2), .SATURATE(1'b0)) dut_wrap (
    .clk50Mhz(clk),
    .rst     (rst),
    .sig     (sig),
    .cnt     (cnt_wrap)
  );

  // 50 MHz clock that can be frozen low for the clockless reset test
  initial clk = 1'b0;
  always begin
    #10;
    if (clk_en) clk = ~clk;
  end

  // Time limit so a broken design can never hang the run
  initial begin
    #1500000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_both(input string name, input logic [15:0] es, input logic [15:0] ew);
    check({name, "_sat"}, cnt_sat, es);
    check({name, "_wrap"}, cnt_wrap, ew);
  endtask

  task automatic clear_model();
    model_sat  = 16'h0000;
    model_wrap = 16'h0000;
    exp_sat_q.delete();
    exp_wrap_q.delete();
  endtask

  // One sig pulse starting at a negedge: hi cycles high, lo cycles low.
  // Verifies no increment after edge k+1 and the increment after edge k+2.
  task automatic pulse(input int hi, input int lo);
    logic [15:0] prev_sat;
    logic [15:0] prev_wrap;
    logic [15:0] es;
    logic [15:0] ew;
    prev_sat  = model_sat;
    prev_wrap = model_wrap;
    sig = 1'b1;
    model_sat  = (model_sat == 16'hFFFF) ? model_sat : model_sat + 16'd1;
    model_wrap = model_wrap + 16'd1;
    exp_sat_q.push_back(model_sat);
    exp_wrap_q.push_back(model_wrap);
    for (int c = 1; c <= hi + lo; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 2) check_both("latency_early", prev_sat, prev_wrap);
      if (c == 3) begin
        if (exp_sat_q.size() == 0 || exp_wrap_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: queue empty, got %h/%h expected entries", cnt_sat, cnt_wrap);
        end else begin
          es = exp_sat_q.pop_front();
          ew = exp_wrap_q.pop_front();
          check_both("increment", es, ew);
        end
      end
      if (c == hi) sig = 1'b0;
    end
  endtask

  // Synchronous-release reset with sig held at the given level
  task automatic do_reset(input logic level);
    @(negedge clk);
    rst = 1'b1;
    sig = level;
    @(posedge clk);
    @(negedge clk);
    check_both("in_reset", 16'h0000, 16'h0000);
    rst = 1'b0;
    clear_model();
  endtask

  initial begin
    clk_en = 1'b1;
    rst    = 1'b1;
    sig    = 1'b0;
    clear_model();

    // Vector table: pulse shapes (cycles) and the count after each one
    for (int i = 0; i < 10; i++) vecs[i] = '{hi: 2, lo: 2, exp: 16'(i + 1)};
    vecs[10] = '{hi: 50, lo: 50, exp: 16'd11};  // 1 us high, 1 us low
    vecs[11] = '{hi: 3,  lo: 4,  exp: 16'd12};
    vecs[12] = '{hi: 7,  lo: 2,  exp: 16'd13};

    #25;
    check_both("reset_value", 16'h0000, 16'h0000);
    do_reset(1'b0);

    // Basic counting, steady levels and assorted widths
    for (int i = 0; i < 13; i++) begin
      pulse(vecs[i].hi, vecs[i].lo);
      check_both("vec_end", vecs[i].exp, vecs[i].exp);
    end

    // Clock stopped: a 1 ns reset pulse must clear the count on its own
    @(negedge clk);
    clk_en = 1'b0;
    #15;
    check_both("pre_async", 16'd13, 16'd13);
    rst = 1'b1;
    #0.5;
    check_both("async_clear", 16'h0000, 16'h0000);
    #0.5;
    rst = 1'b0;
    #100;
    check_both("stopped_clock_hold", 16'h0000, 16'h0000);
    clear_model();
    clk_en = 1'b1;

    // Reset mid-count with a partially synchronized edge in flight
    do_reset(1'b0);
    for (int i = 0; i < 7; i++) pulse(2, 2);
    check_both("seven", 16'd7, 16'd7);
    @(negedge clk);
    sig = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_both("mid_reset_clear", 16'h0000, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      sig = ~sig;
      check_both("held_in_reset", 16'h0000, 16'h0000);
    end
    @(negedge clk);
    sig = 1'b0;
    rst = 1'b0;
    clear_model();
    repeat (4) @(negedge clk);
    check_both("after_release_low", 16'h0000, 16'h0000);
    for (int i = 0; i < 3; i++) pulse($urandom_range(2, 5), $urandom_range(2, 5));
    check_both("three", 16'd3, 16'd3);

    // Release with sig already high counts exactly one edge
    do_reset(1'b1);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check_both("release_high_early", 16'h0000, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    check_both("release_high_edge", 16'd1, 16'd1);
    repeat (10) @(negedge clk);
    check_both("release_high_steady", 16'd1, 16'd1);
    sig = 1'b0;
    repeat (4) @(negedge clk);
    check_both("release_high_fall", 16'd1, 16'd1);
    model_sat  = 16'd1;
    model_wrap = 16'd1;
    pulse(2, 2);
    check_both("release_high_next", 16'd2, 16'd2);

    // Overflow: preload near full scale, then step across 0xFFFF
    @(negedge clk);
    force dut_sat.cnt  = 16'hFFFD;
    force dut_wrap.cnt = 16'hFFFD;
    @(negedge clk);
    release dut_sat.cnt;
    release dut_wrap.cnt;
    @(negedge clk);
    check_both("preload", 16'hFFFD, 16'hFFFD);
    model_sat  = 16'hFFFD;
    model_wrap = 16'hFFFD;
    exp_sat_q.delete();
    exp_wrap_q.delete();
    pulse(2, 2);
    check_both("ovf_fffe", 16'hFFFE, 16'hFFFE);
    pulse(2, 2);
    check_both("ovf_ffff", 16'hFFFF, 16'hFFFF);
    pulse(2, 2);
    check_both("ovf_step", 16'hFFFF, 16'h0000);
    pulse(3, 3);
    check_both("ovf_after", 16'hFFFF, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
